// File: rtl/object_package.sv
// Shared types for the game objects: the match phase enumeration and sequencing constants.
package object_package;

  typedef enum logic [2:0] {
    TITLE = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } game_phase_t;

  localparam int COUNTDOWN_W = 2;
  localparam int POINT_CNT_W = 2;

endpackage

// File: rtl/sec_prescaler.sv
// Divides frame_tick pulses down to one sec_tick per FRAMES_PER_SEC frames; clear restarts the count.
module sec_prescaler #(
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic frame_tick,
  output logic sec_tick
);

  localparam int CW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_SEC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // sec_tick ignores clear so the caller can use it to decide a state change without a loop;
  // the count wraps to zero on that tick anyway.
  assign sec_tick = frame_tick && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (frame_tick) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/match_sequencer.sv
// Match phase sequencer: title, serve countdown, play, point pause and game over, with registered controls.
module match_sequencer
  import object_package::*;
#(
  parameter int FRAMES_PER_SEC = 60,
  parameter int SERVE_SECS     = 3,
  parameter int POINT_SECS     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_tick,
  input  logic                   start_btn,
  input  logic                   out_left,
  input  logic                   out_right,
  input  logic                   gameover,
  output game_phase_t            phase,
  output logic                   ball_hold,
  output logic                   ball_reset,
  output logic                   score_clear,
  output logic                   serve_dir,
  output logic [COUNTDOWN_W-1:0] countdown
);

  localparam logic [COUNTDOWN_W-1:0] SERVE_LOAD = COUNTDOWN_W'(SERVE_SECS);
  localparam logic [POINT_CNT_W-1:0] POINT_LAST = POINT_CNT_W'(POINT_SECS - 1);

  game_phase_t             phase_q, phase_d;
  logic                    ball_hold_q, ball_hold_d;
  logic                    ball_reset_q, ball_reset_d;
  logic                    score_clear_q, score_clear_d;
  logic                    serve_dir_q, serve_dir_d;
  logic [COUNTDOWN_W-1:0]  countdown_q, countdown_d;
  logic [POINT_CNT_W-1:0]  point_cnt_q, point_cnt_d;
  logic                    start_prev_q;
  logic                    start_evt;
  logic                    sec_tick;
  logic                    phase_change;

  assign start_evt    = start_btn && !start_prev_q;
  assign phase_change = (phase_d != phase_q);

  sec_prescaler #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (phase_change),
    .frame_tick(frame_tick),
    .sec_tick  (sec_tick)
  );

  always_comb begin
    phase_d       = phase_q;
    ball_reset_d  = 1'b0;
    score_clear_d = 1'b0;
    serve_dir_d   = serve_dir_q;
    countdown_d   = countdown_q;
    point_cnt_d   = point_cnt_q;

    case (phase_q)
      TITLE: begin
        if (start_evt) begin
          phase_d       = SERVE;
          countdown_d   = SERVE_LOAD;
          score_clear_d = 1'b1;
          ball_reset_d  = 1'b1;
        end
      end
      SERVE: begin
        if (sec_tick) begin
          if (countdown_q <= COUNTDOWN_W'(1)) begin
            phase_d     = PLAY;
            countdown_d = '0;
          end else begin
            countdown_d = countdown_q - COUNTDOWN_W'(1);
          end
        end
      end
      PLAY: begin
        if (gameover) begin
          phase_d = OVER;
        end else if (out_left || out_right) begin
          phase_d     = POINT;
          point_cnt_d = '0;
          // A double exit in one frame alternates the serve rather than favouring a side.
          if (out_left && out_right) begin
            serve_dir_d = !serve_dir_q;
          end else begin
            serve_dir_d = out_right;
          end
        end
      end
      POINT: begin
        if (gameover) begin
          phase_d = OVER;
        end else if (sec_tick) begin
          if (point_cnt_q == POINT_LAST) begin
            phase_d      = SERVE;
            countdown_d  = SERVE_LOAD;
            ball_reset_d = 1'b1;
          end else begin
            point_cnt_d = point_cnt_q + POINT_CNT_W'(1);
          end
        end
      end
      OVER: begin
        if (start_evt) begin
          phase_d       = TITLE;
          score_clear_d = 1'b1;
        end
      end
      default: begin
        phase_d     = TITLE;
        countdown_d = '0;
      end
    endcase

    ball_hold_d = (phase_d != PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= TITLE;
      ball_hold_q   <= 1'b1;
      ball_reset_q  <= 1'b0;
      score_clear_q <= 1'b0;
      serve_dir_q   <= 1'b0;
      countdown_q   <= '0;
      point_cnt_q   <= '0;
      start_prev_q  <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      ball_hold_q   <= ball_hold_d;
      ball_reset_q  <= ball_reset_d;
      score_clear_q <= score_clear_d;
      serve_dir_q   <= serve_dir_d;
      countdown_q   <= countdown_d;
      point_cnt_q   <= point_cnt_d;
      start_prev_q  <= start_btn;
    end
  end

  assign phase       = phase_q;
  assign ball_hold   = ball_hold_q;
  assign ball_reset  = ball_reset_q;
  assign score_clear = score_clear_q;
  assign serve_dir   = serve_dir_q;
  assign countdown   = countdown_q;

endmodule

// File: doc/match_sequencer.md
MATCH_SEQUENCER -- requirements
Module: match_sequencer

Interface
REQ-001 Parameter FRAMES_PER_SEC, default 60: frame_tick pulses per countdown second.
REQ-002 Parameter SERVE_SECS, default 3: serve countdown length in seconds, range 1..3.
REQ-003 Parameter POINT_SECS, default 1: pause after a point in seconds, range 1..3.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 frame_tick  input  1  one-cycle pulse per video frame.
REQ-007 start_btn  input  1  start button level, already synchronized to clk.
REQ-008 out_left  input  1  level; a ball is past the left edge (player 2 scores).
REQ-009 out_right  input  1  level; a ball is past the right edge (player 1 scores).
REQ-010 gameover  input  1  registered game-over flag from the score block.
REQ-011 phase  output  game_phase_t (3 bits)  current state.
REQ-012 ball_hold  output  1  balls frozen at centre, no motion update.
REQ-013 ball_reset  output  1  one-cycle pulse; ball block re-centres balls.
REQ-014 score_clear  output  1  one-cycle pulse; score block clears s1/s2/gameover.
REQ-015 serve_dir  output  1  0 = next serve toward left, 1 = toward right.
REQ-016 countdown  output  2  seconds remaining in SERVE; 0 outside SERVE.

Function
REQ-017 States SHALL be TITLE, SERVE, PLAY, POINT and OVER; all outputs are registered.
REQ-018 Start event SHALL be the rising edge of start_btn (registered previous value); a held button produces one event.
REQ-019 Prescaler SHALL count frame_tick and emit sec_tick on the frame_tick where the count equals FRAMES_PER_SEC-1, then wrap to 0.
REQ-020 Prescaler SHALL clear on the cycle of every state change; a frame_tick on that cycle is not counted.
REQ-021 TITLE: ball_hold=1; a start event SHALL move to SERVE with countdown=SERVE_SECS, one-cycle score_clear and one-cycle ball_reset on the transition edge.
REQ-022 SERVE: ball_hold=1; each sec_tick decrements countdown; sec_tick while countdown==1 SHALL move to PLAY with countdown=0.
REQ-023 PLAY: ball_hold=0; out_left or out_right SHALL move to POINT.
REQ-024 On the PLAY->POINT transition, serve_dir SHALL become 0 if only out_left, 1 if only out_right, and SHALL toggle if both are set in the same cycle.
REQ-025 POINT: ball_hold=1; after POINT_SECS sec_ticks, SHALL move to SERVE with countdown=SERVE_SECS and one ball_reset pulse.
REQ-026 gameover==1 in PLAY or POINT SHALL move to OVER next cycle, taking priority over every other transition.
REQ-027 OVER: ball_hold=1; a start event SHALL move to TITLE with one score_clear pulse.
REQ-028 out_left/out_right SHALL be ignored outside PLAY.
REQ-029 gameover SHALL be ignored in TITLE, SERVE and OVER.
REQ-030 start events SHALL be ignored in SERVE, PLAY and POINT.
REQ-031 ball_reset and score_clear SHALL never be high for two consecutive cycles.

Reset
REQ-032 While rst_n==0, outputs SHALL be: phase=TITLE, ball_hold=1, ball_reset=0, score_clear=0, serve_dir=0, countdown=0; prescaler=0, start edge register=0.
REQ-033 Reset asserted mid-state SHALL take effect immediately (asynchronous) with no pulse emitted.
REQ-034 After rst_n deasserts, a start_btn already high SHALL count as one start event.

Structure
REQ-035 game_phase_t (TITLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4) SHALL be declared in object_package.
REQ-036 The prescaler SHALL be a sub-module sec_prescaler (inputs clk, rst_n, clear, frame_tick; output sec_tick), parameterized by FRAMES_PER_SEC.

Verification (FRAMES_PER_SEC=4, SERVE_SECS=3, POINT_SECS=1)
REQ-037 Reset, then start rising edge -> next cycle phase=SERVE, countdown=3, score_clear and ball_reset high for exactly 1 cycle.
REQ-038 12 frame_ticks in SERVE -> countdown steps 3,2,1; PLAY entered after tick 12 with ball_hold=0.
REQ-039 PLAY with out_left and out_right both set in one cycle, serve_dir=1 -> POINT, serve_dir=0; after 4 frame_ticks -> SERVE with one ball_reset pulse.
REQ-040 out_right in PLAY, gameover raised the next cycle -> POINT then OVER; no ball_reset pulse; start edge -> TITLE with one score_clear pulse.
REQ-041 start_btn held high for 20 cycles in TITLE -> exactly one transition; frame_tick coincident with state entry -> not counted (SERVE lasts 12 further ticks).
REQ-042 rst_n pulled low during PLAY -> same cycle phase=TITLE, ball_hold=1, countdown=0, no pulses.
